// File: rtl/alu_mdu_if.sv
// EX-stage operand/result bundle between the forwarding muxes, the EX/MEM
// register, the HI/LO write port and alu_mdu.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic [7:0]       aluControl;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             valid_in;
  logic             flush;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             stall;
  logic             hilo_we;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output aluControl, x, y, valid_in, flush,
    input  result, zero, overflow, stall, hilo_we, hi_out, lo_out
  );

  modport slave (
    input  aluControl, x, y, valid_in, flush,
    output result, zero, overflow, stall, hilo_we, hi_out, lo_out
  );
endinterface

// File: rtl/alu_mdu.sv
// Execute-stage ALU with signed-overflow detection and an iterative radix-2
// multiply/divide engine that stalls the pipeline until HI/LO are ready.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      resetn,
  alu_mdu_if.slave bus
);
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_ANDI_OP  = 8'b0101_1001;
  localparam logic [7:0] EXE_ORI_OP   = 8'b0101_1010;
  localparam logic [7:0] EXE_XORI_OP  = 8'b0101_1011;
  localparam logic [7:0] EXE_LUI_OP   = 8'b0101_1100;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SLLV_OP  = 8'b0000_0100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRLV_OP  = 8'b0000_0110;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_SRAV_OP  = 8'b0000_0111;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_SLTI_OP  = 8'b0101_0111;
  localparam logic [7:0] EXE_SLTIU_OP = 8'b0101_1000;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [1:0]     S_IDLE   = 2'd0;
  localparam logic [1:0]     S_BUSY   = 2'd1;
  localparam logic [1:0]     S_DONE   = 2'd2;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d, qneg_q, qneg_d, rneg_q, rneg_d, div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0]   res_s, sum_s, dif_s, x_mag_s, y_mag_s, quo_s, rem_s, hi_fix_s, lo_fix_s;
  logic [SHW-1:0]     sh_s;
  logic               ovf_s, add_ovf_s, sub_ovf_s, slt_s, sltu_s;
  logic               md_op_s, signed_op_s, div_op_s, start_s, x_neg_s, y_neg_s;
  logic [WIDTH:0]     mul_sum_s, div_trial_s, div_diff_s;
  logic [2*WIDTH-1:0] step_s, prod_s;

  assign sum_s     = bus.x + bus.y;
  assign dif_s     = bus.x - bus.y;
  assign add_ovf_s = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (sum_s[WIDTH-1] != bus.x[WIDTH-1]);
  assign sub_ovf_s = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) && (dif_s[WIDTH-1] != bus.x[WIDTH-1]);
  assign slt_s     = $signed(bus.x) < $signed(bus.y);
  assign sltu_s    = bus.x < bus.y;
  assign sh_s      = bus.x[SHW-1:0];

  // Single-cycle result and overflow select
  always_comb begin
    res_s = {WIDTH{1'b0}};
    ovf_s = 1'b0;
    case (bus.aluControl)
      EXE_ADD_OP, EXE_ADDI_OP:     begin res_s = sum_s; ovf_s = add_ovf_s; end
      EXE_ADDU_OP, EXE_ADDIU_OP:   res_s = sum_s;
      EXE_SUB_OP:                  begin res_s = dif_s; ovf_s = sub_ovf_s; end
      EXE_SUBU_OP:                 res_s = dif_s;
      EXE_AND_OP, EXE_ANDI_OP:     res_s = bus.x & bus.y;
      EXE_OR_OP, EXE_ORI_OP:       res_s = bus.x | bus.y;
      EXE_XOR_OP, EXE_XORI_OP:     res_s = bus.x ^ bus.y;
      EXE_NOR_OP:                  res_s = ~(bus.x | bus.y);
      EXE_SLT_OP, EXE_SLTI_OP:     res_s = {{(WIDTH-1){1'b0}}, slt_s};
      EXE_SLTU_OP, EXE_SLTIU_OP:   res_s = {{(WIDTH-1){1'b0}}, sltu_s};
      EXE_LUI_OP:                  res_s = {bus.y[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      EXE_SLL_OP, EXE_SLLV_OP:     res_s = bus.y << sh_s;
      EXE_SRL_OP, EXE_SRLV_OP:     res_s = bus.y >> sh_s;
      EXE_SRA_OP, EXE_SRAV_OP:     res_s = $unsigned($signed(bus.y) >>> sh_s);
      EXE_MFHI_OP, EXE_MFLO_OP:    res_s = bus.y;
      EXE_MTHI_OP, EXE_MTLO_OP:    res_s = bus.x;
      default:                     res_s = {WIDTH{1'b0}};
    endcase
  end

  // Multiply/divide request decode
  always_comb begin
    md_op_s     = 1'b0;
    signed_op_s = 1'b0;
    div_op_s    = 1'b0;
    case (bus.aluControl)
      EXE_MULT_OP:  begin md_op_s = 1'b1; signed_op_s = 1'b1; end
      EXE_MULTU_OP: md_op_s = 1'b1;
      EXE_DIV_OP:   begin md_op_s = 1'b1; signed_op_s = 1'b1; div_op_s = 1'b1; end
      EXE_DIVU_OP:  begin md_op_s = 1'b1; div_op_s = 1'b1; end
      default:      md_op_s = 1'b0;
    endcase
  end

  assign start_s = (state_q == S_IDLE) && bus.valid_in && !bus.flush && md_op_s;
  assign x_neg_s = signed_op_s && bus.x[WIDTH-1];
  assign y_neg_s = signed_op_s && bus.y[WIDTH-1];
  assign x_mag_s = x_neg_s ? ({WIDTH{1'b0}} - bus.x) : bus.x;
  assign y_mag_s = y_neg_s ? ({WIDTH{1'b0}} - bus.y) : bus.y;

  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign div_trial_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff_s  = div_trial_s - {1'b0, opnd_q};

  // One radix-2 iteration of the engine
  always_comb begin
    step_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (!div_diff_s[WIDTH]) begin
        step_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        step_s = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    end
  end

  assign prod_s = qneg_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
  assign quo_s  = acc_q[WIDTH-1:0];
  assign rem_s  = acc_q[2*WIDTH-1:WIDTH];

  // Sign correction of the finished HI/LO pair
  always_comb begin
    hi_fix_s = prod_s[2*WIDTH-1:WIDTH];
    lo_fix_s = prod_s[WIDTH-1:0];
    if (is_div_q) begin
      hi_fix_s = rneg_q ? ({WIDTH{1'b0}} - rem_s) : rem_s;
      if (div0_q) begin
        lo_fix_s = {WIDTH{1'b1}};
      end else begin
        lo_fix_s = qneg_q ? ({WIDTH{1'b0}} - quo_s) : quo_s;
      end
    end else begin
      hi_fix_s = prod_s[2*WIDTH-1:WIDTH];
      lo_fix_s = prod_s[WIDTH-1:0];
    end
  end

  // Engine sequencing
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          state_d  = S_BUSY;
          cnt_d    = {SHW{1'b0}};
          acc_d    = {{WIDTH{1'b0}}, (div_op_s ? x_mag_s : y_mag_s)};
          opnd_d   = div_op_s ? y_mag_s : x_mag_s;
          is_div_d = div_op_s;
          qneg_d   = x_neg_s ^ y_neg_s;
          rneg_d   = x_neg_s;
          div0_d   = (bus.y == {WIDTH{1'b0}});
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = step_s;
          cnt_d   = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
          state_d = (cnt_q == CNT_LAST) ? S_DONE : S_BUSY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        hi_d    = hi_fix_s;
        lo_d    = lo_fix_s;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= {SHW{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.result   = res_s;
  assign bus.zero     = (res_s == {WIDTH{1'b0}});
  assign bus.overflow = ovf_s;
  assign bus.stall    = resetn && (start_s || ((state_q == S_BUSY) && !bus.flush));
  assign bus.hilo_we  = (state_q == S_DONE);
  assign bus.hi_out   = (state_q == S_DONE) ? hi_fix_s : hi_q;
  assign bus.lo_out   = (state_q == S_DONE) ? lo_fix_s : lo_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: randomized ALU ops and multiply/divide
// transactions against a plain-arithmetic reference model.
module tb_alu_mdu;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_ANDI_OP  = 8'b0101_1001;
  localparam logic [7:0] EXE_ORI_OP   = 8'b0101_1010;
  localparam logic [7:0] EXE_XORI_OP  = 8'b0101_1011;
  localparam logic [7:0] EXE_LUI_OP   = 8'b0101_1100;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SLLV_OP  = 8'b0000_0100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRLV_OP  = 8'b0000_0110;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_SRAV_OP  = 8'b0000_0111;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_SLTI_OP  = 8'b0101_0111;
  localparam logic [7:0] EXE_SLTIU_OP = 8'b0101_1000;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam longint     MAXI         = 64'sd2147483647;
  localparam longint     MINI         = -64'sd2147483648;

  logic clk;
  logic resetn;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_mdu_if #(.WIDTH(32)) bus ();
  alu_mdu #(.WIDTH(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] sc_op(input int k);
    case (k)
      0: return EXE_ADD_OP;    1: return EXE_ADDI_OP;   2: return EXE_ADDU_OP;
      3: return EXE_ADDIU_OP;  4: return EXE_SUB_OP;    5: return EXE_SUBU_OP;
      6: return EXE_AND_OP;    7: return EXE_ANDI_OP;   8: return EXE_OR_OP;
      9: return EXE_ORI_OP;   10: return EXE_XOR_OP;   11: return EXE_XORI_OP;
     12: return EXE_NOR_OP;   13: return EXE_SLT_OP;   14: return EXE_SLTI_OP;
     15: return EXE_SLTU_OP;  16: return EXE_SLTIU_OP; 17: return EXE_LUI_OP;
     18: return EXE_SLL_OP;   19: return EXE_SLLV_OP;  20: return EXE_SRL_OP;
     21: return EXE_SRLV_OP;  22: return EXE_SRA_OP;   23: return EXE_SRAV_OP;
     24: return EXE_MFHI_OP;  25: return EXE_MFLO_OP;  26: return EXE_MTHI_OP;
     27: return EXE_MTLO_OP;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Returns {overflow, result}
  function automatic logic [32:0] ref_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        o;
    longint      s;
    int          sh;
    r  = 32'd0;
    o  = 1'b0;
    sh = int'(a[4:0]);
    case (op)
      EXE_ADD_OP, EXE_ADDI_OP: begin
        s = longint'(int'(a)) + longint'(int'(b));
        r = 32'(s);
        o = (s > MAXI) || (s < MINI);
      end
      EXE_ADDU_OP, EXE_ADDIU_OP: r = a + b;
      EXE_SUB_OP: begin
        s = longint'(int'(a)) - longint'(int'(b));
        r = 32'(s);
        o = (s > MAXI) || (s < MINI);
      end
      EXE_SUBU_OP:               r = a - b;
      EXE_AND_OP, EXE_ANDI_OP:   r = a & b;
      EXE_OR_OP, EXE_ORI_OP:     r = a | b;
      EXE_XOR_OP, EXE_XORI_OP:   r = a ^ b;
      EXE_NOR_OP:                r = ~(a | b);
      EXE_SLT_OP, EXE_SLTI_OP:   r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      EXE_SLTU_OP, EXE_SLTIU_OP: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      EXE_LUI_OP:                r = b * 32'd65536;
      EXE_SLL_OP, EXE_SLLV_OP: begin
        r = b;
        for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0};
      end
      EXE_SRL_OP, EXE_SRLV_OP: begin
        r = b;
        for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]};
      end
      EXE_SRA_OP, EXE_SRAV_OP: begin
        r = b;
        for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
      end
      EXE_MFHI_OP, EXE_MFLO_OP:  r = b;
      EXE_MTHI_OP, EXE_MTLO_OP:  r = a;
      default:                   r = 32'd0;
    endcase
    return {o, r};
  endfunction

  // Returns {hi, lo}
  function automatic logic [63:0] ref_md(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q, r;
    if (op == EXE_MULT_OP) begin
      p = longint'(int'(a)) * longint'(int'(b));
      return 64'(p);
    end else if (op == EXE_MULTU_OP) begin
      return {32'd0, a} * {32'd0, b};
    end else if (b == 32'd0) begin
      return {a, 32'hFFFF_FFFF};
    end else if (op == EXE_DIV_OP) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = int'(a) / int'(b);
      r = int'(a) % int'(b);
      return {32'(r), 32'(q)};
    end else begin
      return {a % b, a / b};
    end
  endfunction

  task automatic do_md(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [63:0] exp_hl;
    exp_hl = ref_md(op, a, b);
    @(posedge clk); #1;
    bus.aluControl = op; bus.x = a; bus.y = b; bus.valid_in = 1'b1; bus.flush = 1'b0;
    #1;
    n_cmp++;
    if (bus.stall !== 1'b1) begin
      n_err++; $display("FAIL md_issue_stall op=%h: got %b want 1", op, bus.stall);
    end
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk); #1;
      if (!hold) begin
        bus.valid_in = 1'b0; bus.aluControl = 8'($urandom); bus.x = $urandom; bus.y = $urandom;
      end
      #1;
      n_cmp++;
      if (c <= 32) begin
        if ({bus.stall, bus.hilo_we} !== 2'b10) begin
          n_err++; $display("FAIL md_busy op=%h cyc=%0d: stall,we=%b want 10", op, c, {bus.stall, bus.hilo_we});
        end
      end else begin
        if ({bus.stall, bus.hilo_we, bus.hi_out, bus.lo_out} !== {2'b01, exp_hl}) begin
          n_err++;
          $display("FAIL md_done op=%h x=%h y=%h: stall=%b we=%b hi=%h lo=%h want hi=%h lo=%h",
                   op, a, b, bus.stall, bus.hilo_we, bus.hi_out, bus.lo_out, exp_hl[63:32], exp_hl[31:0]);
        end
      end
    end
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    #1;
    n_cmp++;
    if ({bus.stall, bus.hilo_we, bus.hi_out, bus.lo_out} !== {2'b00, exp_hl}) begin
      n_err++;
      $display("FAIL md_hold op=%h: stall=%b we=%b hi=%h lo=%h want hi=%h lo=%h",
               op, bus.stall, bus.hilo_we, bus.hi_out, bus.lo_out, exp_hl[63:32], exp_hl[31:0]);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.aluControl = EXE_MULT_OP; bus.x = 32'd5; bus.y = 32'd3; bus.valid_in = 1'b1; bus.flush = 1'b0;
    #3;
    n_cmp++;
    if ({bus.stall, bus.hilo_we, bus.hi_out, bus.lo_out} !== 66'd0) begin
      n_err++; $display("FAIL reset_outputs: stall=%b we=%b hi=%h lo=%h want all 0",
                        bus.stall, bus.hilo_we, bus.hi_out, bus.lo_out);
    end
    bus.valid_in = 1'b0;
    #19 resetn = 1'b1;
  endtask

  task automatic test_alu_directed();
    logic [7:0]  t_op [8] = '{EXE_ADD_OP, EXE_ADDU_OP, EXE_SLT_OP, EXE_SLTU_OP,
                              EXE_SRA_OP, EXE_SUB_OP, EXE_LUI_OP, EXE_MULT_OP};
    logic [31:0] t_x [8]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd4, 32'h8000_0000, 32'h5555_5555, 32'd9};
    logic [31:0] t_y [8]  = '{32'd1, 32'd1, 32'd1, 32'd1,
                              32'h8000_0000, 32'd1, 32'h1234_ABCD, 32'd9};
    logic [31:0] t_r [8]  = '{32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0,
                              32'hF800_0000, 32'h7FFF_FFFF, 32'hABCD_0000, 32'd0};
    logic        t_o [8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.aluControl = t_op[i]; bus.x = t_x[i]; bus.y = t_y[i]; bus.valid_in = (i != 7); bus.flush = 1'b0;
      #1;
      n_cmp++;
      if ({bus.result, bus.overflow, bus.zero, bus.stall} !== {t_r[i], t_o[i], (t_r[i] == 32'd0), 1'b0}) begin
        n_err++; $display("FAIL alu_directed[%0d]: res=%h ovf=%b zero=%b stall=%b want res=%h ovf=%b",
                          i, bus.result, bus.overflow, bus.zero, bus.stall, t_r[i], t_o[i]);
      end
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic test_alu_random();
    logic [32:0] e;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      bus.x = rnd_val(); bus.y = rnd_val(); bus.flush = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        bus.aluControl = 8'h18 + 8'($urandom_range(0, 3));
        bus.valid_in   = 1'b0;
      end else begin
        bus.aluControl = sc_op($urandom_range(0, 28));
        bus.valid_in   = 1'($urandom_range(0, 1));
      end
      e = ref_alu(bus.aluControl, bus.x, bus.y);
      #1;
      n_cmp++;
      if ({bus.result, bus.overflow, bus.zero, bus.stall} !== {e[31:0], e[32], (e[31:0] == 32'd0), 1'b0}) begin
        n_err++; $display("FAIL alu_random op=%h x=%h y=%h: res=%h ovf=%b zero=%b stall=%b want res=%h ovf=%b",
                          bus.aluControl, bus.x, bus.y, bus.result, bus.overflow, bus.zero, bus.stall, e[31:0], e[32]);
      end
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic test_md_directed();
    do_md(EXE_MULT_OP, 32'hFFFF_FFFD, 32'd7, 1'b0);
    do_md(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_md(EXE_DIVU_OP, 32'd7, 32'd0, 1'b0);
    do_md(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd0, 1'b0);
    do_md(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_md(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_md_random();
    logic [7:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      op = 8'h18 + 8'($urandom_range(0, 3));
      a  = rnd_val();
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : rnd_val();
      do_md(op, a, b, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    do_md(EXE_DIVU_OP, $urandom, 32'($urandom_range(1, 500)), 1'b1);
    do_md(EXE_MULT_OP, $urandom, $urandom, 1'b1);
    do_md(EXE_DIV_OP, $urandom, $urandom, 1'b0);
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    bus.aluControl = EXE_MULTU_OP; bus.x = $urandom; bus.y = $urandom; bus.valid_in = 1'b1; bus.flush = 1'b0;
    #1;
    n_cmp++;
    if (bus.stall !== 1'b1) begin
      n_err++; $display("FAIL flush_issue_stall: got %b want 1", bus.stall);
    end
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      bus.valid_in = 1'b0; bus.flush = (c == 10);
      #1;
      n_cmp++;
      if ({bus.stall, bus.hilo_we} !== ((c < 10) ? 2'b10 : 2'b00)) begin
        n_err++; $display("FAIL flush_cycle cyc=%0d: stall,we=%b want %b", c, {bus.stall, bus.hilo_we},
                          (c < 10) ? 2'b10 : 2'b00);
      end
    end
    bus.flush = 1'b0;
    do_md(EXE_DIVU_OP, $urandom, 32'($urandom_range(1, 1000)), 1'b0);
    @(posedge clk); #1;
    bus.aluControl = EXE_DIV_OP; bus.x = 32'd100; bus.y = 32'd7; bus.valid_in = 1'b1; bus.flush = 1'b1;
    #1;
    n_cmp++;
    if (bus.stall !== 1'b0) begin
      n_err++; $display("FAIL flush_idle_stall: got %b want 0", bus.stall);
    end
    @(posedge clk); #1;
    bus.valid_in = 1'b0; bus.flush = 1'b0;
    #1;
    n_cmp++;
    if ({bus.stall, bus.hilo_we} !== 2'b00) begin
      n_err++; $display("FAIL flush_idle_nostart: stall,we=%b want 00", {bus.stall, bus.hilo_we});
    end
  endtask

  task automatic test_reset_midflight();
    do_md(EXE_MULT_OP, 32'hFFFF_FFFD, 32'd7, 1'b0);
    @(posedge clk); #1;
    bus.aluControl = EXE_DIV_OP; bus.x = 32'hFFFF_FF00; bus.y = 32'd5; bus.valid_in = 1'b1; bus.flush = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
    end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.stall, bus.hilo_we, bus.hi_out, bus.lo_out} !== 66'd0) begin
      n_err++; $display("FAIL reset_midflight: stall=%b we=%b hi=%h lo=%h want all 0",
                        bus.stall, bus.hilo_we, bus.hi_out, bus.lo_out);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      n_cmp++;
      if ({bus.stall, bus.hilo_we, bus.hi_out, bus.lo_out} !== 66'd0) begin
        n_err++; $display("FAIL reset_discard cyc=%0d: stall=%b we=%b hi=%h lo=%h want all 0",
                          c, bus.stall, bus.hilo_we, bus.hi_out, bus.lo_out);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_md_directed();
    test_md_random();
    test_back_to_back();
    test_flush();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
